// File: rtl/sysarr_drain_control.sv
// Write-side drain controller for the systolic array: turns the column skew of the
// result stream into per-bank write enables and row-aligned write addresses.
module sysarr_drain_control #(
  parameter int WIDTH_HEIGHT  = 16,
  parameter int ADDR_WIDTH    = 8,
  parameter int ARRAY_LATENCY = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [ADDR_WIDTH-1:0]              num_rows,
  input  logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] wr_addr_base,
  output logic [WIDTH_HEIGHT-1:0]            wr_en,
  output logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] wr_addr,
  output logic                               busy,
  output logic                               done
);

  localparam int TW     = ADDR_WIDTH + $clog2(WIDTH_HEIGHT) + 1;
  localparam int LW     = $clog2(ARRAY_LATENCY + 1);
  localparam int LAT_LD = (ARRAY_LATENCY > 1) ? ARRAY_LATENCY - 2 : 0;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN, FIN} state_e;

  state_e                               state_q, state_d;
  logic [LW-1:0]                        lat_q, lat_d;
  logic [TW-1:0]                        t_q, t_d;
  logic [ADDR_WIDTH-1:0]                nrows_q, nrows_d;
  logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0]   base_q, base_d;
  logic [WIDTH_HEIGHT-1:0]              en_q, en_d;
  logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [TW-1:0]                        last_t;

  // t of the cycle where the last column writes its last row
  assign last_t = TW'(nrows_q) + TW'(WIDTH_HEIGHT) - TW'(2);

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    t_d     = t_q;
    nrows_d = nrows_q;
    base_d  = base_q;
    case (state_q)
      IDLE: if (start) begin
        nrows_d = num_rows;
        base_d  = wr_addr_base;
        t_d     = '0;
        if (num_rows == '0)          state_d = FIN;
        else if (ARRAY_LATENCY == 1) state_d = DRAIN;
        else begin
          state_d = WAIT;
          lat_d   = LW'(LAT_LD);
        end
      end
      WAIT: begin
        if (lat_q == '0) state_d = DRAIN;
        else             lat_d   = lat_q - LW'(1);
      end
      DRAIN: begin
        if (t_q == last_t) state_d = FIN;
        else               t_d     = t_q + TW'(1);
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from next-state so they are registered yet aligned with DRAIN
  for (genvar c = 0; c < WIDTH_HEIGHT; c++) begin : g_col
    assign en_d[c] = (state_d == DRAIN) && (t_d >= TW'(c)) &&
                     (t_d < TW'(c) + TW'(nrows_d));
    assign addr_d[c*ADDR_WIDTH +: ADDR_WIDTH] = en_d[c] ?
      base_d[c*ADDR_WIDTH +: ADDR_WIDTH] + ADDR_WIDTH'(t_d - TW'(c)) :
      addr_q[c*ADDR_WIDTH +: ADDR_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lat_q   <= '0;
      t_q     <= '0;
      nrows_q <= '0;
      base_q  <= '0;
      en_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      t_q     <= t_d;
      nrows_q <= nrows_d;
      base_q  <= base_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
    end
  end

  assign wr_en   = en_q;
  assign wr_addr = addr_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == FIN);

endmodule
